mux_gate_arbiter: RTL and testbench

- Shares one registered, mux-built bitwise logic unit (NOT/AND/OR/XOR, every bit formed from 2:1 muxes) between N requesters.
- Requesters are served with round-robin arbitration.
- One operation is accepted per cycle; its result is returned with the requester ID through a single valid/ready response channel.
- Sits between the combinational mux-gate datapath and the client blocks that issue gate operations.

---
 rtl/mux_gate_arbiter.sv | 86 ++++++++
 tb/tb_mux_gate_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_gate_arbiter.sv
// mux_gate_arbiter: round-robin share of one registered mux-built NOT/AND/OR/XOR unit among N requesters
module mux_gate_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [2*N-1:0]   req_op,
  input  logic [W*N-1:0]   req_a,
  input  logic [W*N-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_data
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] ptr, win;
  logic [2*N-1:0] rot;
  logic [IDW:0] pos;
  logic found, slot_free, accept;
  logic [1:0] op;
  logic [W-1:0] a, b, res;
  // first valid requester at or after ptr, wrapping modulo N
  always_comb begin
    rot = {req_valid, req_valid} >> ptr;
    found = 1'b0;
    win = '0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos = {1'b0, ptr} + (IDW+1)'(k);
        win = (pos >= (IDW+1)'(N)) ? IDW'(pos - (IDW+1)'(N)) : IDW'(pos);
      end
    end
  end
  // operand mux: pick the winning requester's op and operands
  always_comb begin
    op = '0;
    a = '0;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (win == IDW'(i)) begin
        op = req_op[2*i +: 2];
        a = req_a[W*i +: W];
        b = req_b[W*i +: W];
      end
    end
  end
  // each result bit is a 2:1 mux selected by a[k]; the op chooses the two mux inputs
  always_comb begin
    res = '0;
    for (int k = 0; k < W; k++)
      res[k] = a[k] ? (op == 2'b00 ? 1'b0 : op == 2'b01 ? b[k] : op == 2'b10 ? 1'b1 : ~b[k])
                    : (op == 2'b00 ? 1'b1 : op == 2'b01 ? 1'b0 : b[k]);
  end
  // next-state and handshake outputs: accept whenever the response slot frees this cycle
  always_comb begin
    slot_free = (state == EMPTY) || rsp_ready;
    accept = found && slot_free;
    req_ready = (accept && rst_n) ? (N'(1) << win) : '0;
    rsp_valid = (state == FULL);
    state_nx = accept ? FULL : (state == FULL && rsp_ready) ? EMPTY : state;
  end
  // response state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  end
  // capture result and id on accept; advance pointer past the winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else if (accept) begin
      ptr <= (win == IDW'(N-1)) ? '0 : win + 1'b1;
      rsp_id <= win;
      rsp_data <= res;
    end
  end
endmodule

// File: tb/tb_mux_gate_arbiter.sv
// tb_mux_gate_arbiter: randomized and directed checks against a behavioural model
module tb_mux_gate_arbiter;
  localparam int N = 4, W = 8, IDW = 2;
  logic clk = 0, rst_n = 0, rsp_ready = 0, rsp_valid;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_a = '0, req_b = '0;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_data;
  int checks = 0, errors = 0;
  int m_ptr = 0;
  bit m_full = 0;
  logic [W-1:0] m_data = '0;
  logic [IDW-1:0] m_id = '0;

  mux_gate_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gate(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00: return ~a;
      2'b01: return a & b;
      2'b10: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int winner();
    if (!rst_n || (m_full && !rsp_ready)) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] v = '0;
    int w = winner();
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    int w = winner();
    @(posedge clk);
    if (w >= 0) begin
      m_data = gate(req_op[2*w +: 2], req_a[W*w +: W], req_b[W*w +: W]);
      m_id = IDW'(w);
      m_full = 1;
      m_ptr = (w + 1) % N;
    end else if (m_full && rsp_ready) m_full = 0;
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W] = a;
    req_b[W*i +: W] = b;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_data = '0; m_id = '0;
  endtask

  task automatic do_reset();
    rst_n = 0; req_valid = '0; rsp_ready = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_initial got v=%b d=%h id=%h rdy=%b exp 0 00 0 0000", rsp_valid, rsp_data, rsp_id, req_ready);
    end
    do_reset();
    set_req(1, 2'b00, 8'h00, 8'h00);
    req_valid = 4'b0010; rsp_ready = 0;
    tick();
    req_valid = 4'b0000;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_id !== 2'd1) begin
      errors++; $display("FAIL reset_held got v=%b d=%h id=%h exp 1 ff 1", rsp_valid, rsp_data, rsp_id);
    end
    req_valid = '1;
    #1 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_async got v=%b d=%h id=%h rdy=%b exp 0 00 0 0000", rsp_valid, rsp_data, rsp_id, req_ready);
    end
    #1 rst_n = 1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant got %b exp 0001", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_ops();
    logic [W-1:0] want [4] = '{8'h5A, 8'h24, 8'hBD, 8'h99};
    do_reset();
    rsp_ready = 1; req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      set_req(2, 2'(k), 8'hA5, 8'h3C);
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++; $display("FAIL ops_ready op=%0d got %b exp 0100", k, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== want[k] || rsp_id !== 2'd2) begin
        errors++; $display("FAIL ops_result op=%0d got v=%b d=%h id=%0d exp 1 %h 2", k, rsp_valid, rsp_data, rsp_id, want[k]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 8'(8'h11 * (i + 1)), 8'h0F);
    req_valid = '1; rsp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (req_ready !== (N'(1) << order[k])) begin
        errors++; $display("FAIL rr_grant step=%0d got %b exp idx %0d", k, req_ready, order[k]);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(order[k]) || rsp_data !== m_data) begin
        errors++; $display("FAIL rr_rsp step=%0d got v=%b id=%0d d=%h exp 1 %0d %h", k, rsp_valid, rsp_id, rsp_data, order[k], m_data);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [IDW-1:0] hid = m_id;
    logic [W-1:0] hdata = m_data;
    rsp_ready = 0; req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL bp_ready cyc=%0d got %b exp 0000", k, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== hid || rsp_data !== hdata) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%b id=%0d d=%h exp 1 %0d %h", k, rsp_valid, rsp_id, rsp_data, hid, hdata);
      end
    end
    rsp_ready = 1;
    #1;
    checks++;
    if (req_ready !== exp_ready() || req_ready === '0) begin
      errors++; $display("FAIL bp_release got %b exp %b", req_ready, exp_ready());
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== m_id || rsp_data !== m_data) begin
      errors++; $display("FAIL bp_new got v=%b id=%0d d=%h exp 1 %0d %h", rsp_valid, rsp_id, rsp_data, m_id, m_data);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1;
    set_req(1, 2'b01, 8'hF0, 8'h3C);
    set_req(2, 2'b10, 8'h01, 8'h02);
    set_req(3, 2'b11, 8'hFF, 8'h0F);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_first got %b exp 1000", req_ready);
    end
    tick();
    checks++;
    if (rsp_id !== 2'd3 || rsp_data !== 8'hF0) begin
      errors++; $display("FAIL wrap_rsp3 got id=%0d d=%h exp 3 f0", rsp_id, rsp_data);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_second got %b exp 0010", req_ready);
    end
    tick();
    checks++;
    if (rsp_id !== 2'd1 || rsp_data !== 8'h30) begin
      errors++; $display("FAIL wrap_rsp1 got id=%0d d=%h exp 1 30", rsp_id, rsp_data);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_idle_consume();
    do_reset();
    rsp_ready = 1;
    set_req(0, 2'b11, 8'h55, 8'hF0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
      errors++; $display("FAIL idle_one got v=%b d=%h exp 1 a5", rsp_valid, rsp_data);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 8'hA5 || rsp_id !== 2'd0) begin
        errors++; $display("FAIL idle_drop cyc=%0d got v=%b d=%h id=%0d exp 0 a5 0", k, rsp_valid, rsp_data, rsp_id);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      req_op = (2*N)'($urandom);
      req_a = (W*N)'($urandom);
      req_b = (W*N)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready cyc=%0d got %b exp %b", k, req_ready, exp_ready());
      end
      tick();
      checks++;
      if (rsp_valid !== m_full || rsp_id !== m_id || rsp_data !== m_data) begin
        errors++; $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d d=%h exp %b %0d %h", k, rsp_valid, rsp_id, rsp_data, m_full, m_id, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_round_robin();
    test_back_pressure();
    test_wrap();
    test_idle_consume();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
